uart_tx_ctrl: RTL

UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

---
 rtl/uart_tx_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/uart_tx_ctrl.sv
// Purpose : control FSM for a UART transmitter; sequences start, data, optional parity and stop bits.
// Latency : data_load is combinational on the accepting cycle; START appears on the line the next CLK cycle.
// Backpr. : requests are only accepted in IDLE or STOP; Data_Valid is dropped (never queued) mid-frame.
//
// Ports:
//   CLK         bit-rate clock; one cycle is one serial bit period
//   RST         synchronous active-low reset
//   Data_Valid  request to send the word currently on the datapath
//   PAR_EN      frame carries a parity bit (latched at accept)
//   PAR_TYP     parity type (latched at accept, exported as par_typ_q)
//   data_load   accept strobe; datapath captures its word on this edge
//   ser_en      serializer shift enable (DATA only)
//   bit_idx     index of the data bit on the line, LSB first; 0 outside DATA
//   mux_sel     line select: 00 start, 01 stop/idle, 10 data, 11 parity
//   par_typ_q   parity type for the frame in progress
//   busy        frame in progress (START through STOP)
//   frame_done  one-cycle pulse during the STOP bit
module uart_tx_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     Data_Valid,
  input  logic                     PAR_EN,
  input  logic                     PAR_TYP,
  output logic                     data_load,
  output logic                     ser_en,
  output logic [$clog2(WIDTH)-1:0] bit_idx,
  output logic [1:0]               mux_sel,
  output logic                     par_typ_q,
  output logic                     busy,
  output logic                     frame_done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;
  logic            par_en_q;
  logic            accept_ok;

  // STOP doubles as an accept slot so back-to-back frames need no idle gap.
  assign accept_ok = (state_q == IDLE) || (state_q == STOP);
  // RST is folded in so no capture strobe reaches the datapath while in reset.
  assign data_load = Data_Valid & accept_ok & RST;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // Frame options are frozen at accept so mid-frame input changes are harmless.
      if (data_load) begin
        par_en_q  <= PAR_EN;
        par_typ_q <= PAR_TYP;
      end
    end
  end

  // Next-state and bit counter. The counter is held at zero outside DATA, so it
  // starts every data phase at bit 0 and can never wrap inside it.
  always_comb begin
    state_d = IDLE;
    cnt_d   = '0;
    case (state_q)
      IDLE:   state_d = Data_Valid ? START : IDLE;
      START:  state_d = DATA;
      DATA: begin
        if (cnt_q == LAST_IDX) begin
          state_d = par_en_q ? PARITY : STOP;
        end else begin
          state_d = DATA;
          cnt_d   = cnt_q + CW'(1);
        end
      end
      PARITY: state_d = STOP;
      STOP:   state_d = Data_Valid ? START : IDLE;
      default: state_d = IDLE;  // unused encodings recover to IDLE
    endcase
  end

  // Line-side outputs decoded purely from registered state.
  always_comb begin
    mux_sel    = 2'b01;
    busy       = 1'b0;
    ser_en     = 1'b0;
    frame_done = 1'b0;
    bit_idx    = '0;
    case (state_q)
      START: begin
        mux_sel = 2'b00;
        busy    = 1'b1;
      end
      DATA: begin
        mux_sel = 2'b10;
        busy    = 1'b1;
        ser_en  = 1'b1;
        bit_idx = cnt_q;
      end
      PARITY: begin
        mux_sel = 2'b11;
        busy    = 1'b1;
      end
      STOP: begin
        mux_sel    = 2'b01;
        busy       = 1'b1;
        frame_done = 1'b1;
      end
      default: begin
        mux_sel = 2'b01;
      end
    endcase
  end

endmodule
